// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table, segment bit positions, decoder types.
package seg7_pkg;

    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [7:0] SEG7_BLANK = 8'hFF;

    // Active-low {a..g,dp} with the decimal point off, index = hex value
    localparam logic [7:0] SEG7_HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [3:0] nibble;
        logic       err;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Recovered-frame handshake between the scan decoder and its consumer.
interface seg7_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] frame_value;
    logic [NUM_DIGITS-1:0]   frame_dp;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;

    modport master (
        output frame_value, frame_dp, frame_err, frame_valid, overrun,
        input  frame_ready
    );

    modport slave (
        input  frame_value, frame_dp, frame_err, frame_valid, overrun,
        output frame_ready
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low a..g pattern to a hex nibble.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output seg7_dec_t  dec_c_o
);

    always_comb begin
        dec_c_o.nibble = 4'h0;
        dec_c_o.err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG7_HEX[i][SEG_A:SEG_G]) begin
                dec_c_o.nibble = 4'(i);
                dec_c_o.err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low display bus and rebuilds one hex frame per full scan.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_in,
    input  logic [NUM_DIGITS-1:0] an_in,
    seg7_scan_decoder_if.master   frm
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned VAL_W  = 4 * NUM_DIGITS;

    dec_state_e              state_q, state_d;
    logic [7:0]              lat_seg_q, lat_seg_d;
    logic [NUM_DIGITS-1:0]   lat_an_q, lat_an_d;
    logic [STAB_W-1:0]       stab_q, stab_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [VAL_W-1:0]        stg_val_q, stg_val_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]   stg_err_q, stg_err_d;
    logic [VAL_W-1:0]        frame_value_q, frame_value_d;
    logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    active_c;
    logic                    changed_c;
    logic                    capture_c;
    logic                    publish_c;
    logic                    timeout_c;
    logic [IDX_W-1:0]        idx_c;
    seg7_dec_t               dec_c;

    seg7_pattern_decode u_decode (
        .seg_i   (lat_seg_q[SEG_A:SEG_G]),
        .dec_c_o (dec_c)
    );

    assign active_c  = $onehot(~an_in);
    assign changed_c = (seg_in != lat_seg_q) || (an_in != lat_an_q);
    assign publish_c = &seen_q;

    // Digit index of the latched (one-hot low) enable
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!lat_an_q[i]) idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_seg_d     = lat_seg_q;
        lat_an_d      = lat_an_q;
        stab_d        = stab_q;
        to_cnt_d      = to_cnt_q;
        seen_d        = seen_q;
        stg_val_d     = stg_val_q;
        stg_dp_d      = stg_dp_q;
        stg_err_d     = stg_err_q;
        frame_value_d = frame_value_q;
        frame_dp_d    = frame_dp_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        capture_c     = 1'b0;
        timeout_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (active_c) begin
                    lat_seg_d = seg_in;
                    lat_an_d  = an_in;
                    stab_d    = STAB_W'(1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (changed_c) begin
                    if (active_c) begin
                        lat_seg_d = seg_in;
                        lat_an_d  = an_in;
                        stab_d    = STAB_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (stab_q == STAB_W'(STABLE_CYCLES)) begin
                    capture_c = 1'b1;
                    state_d   = HOLD;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            HOLD: begin
                if (changed_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Inactivity timer: saturating, restarted by every capture
        if (capture_c) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            timeout_c = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
        end

        if (publish_c) seen_d = '0;

        if (timeout_c) begin
            seen_d    = '0;
            stg_val_d = '0;
            stg_dp_d  = '0;
            stg_err_d = '0;
        end

        if (capture_c) begin
            seen_d[idx_c]             = 1'b1;
            stg_val_d[4*idx_c +: 4]   = dec_c.nibble;
            stg_dp_d[idx_c]           = ~lat_seg_q[SEG_DP];
            stg_err_d[idx_c]          = dec_c.err;
        end

        // A held, unaccepted frame wins; a new one arriving then is dropped
        if (publish_c) begin
            if (frame_valid_q && !frm.frame_ready) begin
                overrun_d = 1'b1;
            end else begin
                frame_value_d = stg_val_q;
                frame_dp_d    = stg_dp_q;
                frame_err_d   = stg_err_q;
                frame_valid_d = 1'b1;
            end
        end else if (frame_valid_q && frm.frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lat_seg_q     <= SEG7_BLANK;
            lat_an_q      <= '1;
            stab_q        <= '0;
            to_cnt_q      <= '0;
            seen_q        <= '0;
            stg_val_q     <= '0;
            stg_dp_q      <= '0;
            stg_err_q     <= '0;
            frame_value_q <= '0;
            frame_dp_q    <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_seg_q     <= lat_seg_d;
            lat_an_q      <= lat_an_d;
            stab_q        <= stab_d;
            to_cnt_q      <= to_cnt_d;
            seen_q        <= seen_d;
            stg_val_q     <= stg_val_d;
            stg_dp_q      <= stg_dp_d;
            stg_err_q     <= stg_err_d;
            frame_value_q <= frame_value_d;
            frame_dp_q    <= frame_dp_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frm.frame_value = frame_value_q;
    assign frm.frame_dp    = frame_dp_q;
    assign frm.frame_err   = frame_err_q;
    assign frm.frame_valid = frame_valid_q;
    assign frm.overrun     = overrun_q;

endmodule
